// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and widths for the single-port memory arbiter.
//   REG_BUS      : default address/data width of the core's register bus
//   arb_state_e  : arbiter FSM state encoding (IDLE, REQ, WAIT, RESP)
//   arb_owner_e  : which client owns the outstanding transaction (INST, DATA)
package mem_arbiter_pkg;

  localparam int REG_BUS = 64;

  typedef enum logic [1:0] {
    MEM_ARB_IDLE = 2'd0,
    MEM_ARB_REQ  = 2'd1,
    MEM_ARB_WAIT = 2'd2,
    MEM_ARB_RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    MEM_OWNER_INST = 1'b0,
    MEM_OWNER_DATA = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: grant selection between the fetch and load/store clients.
// Optional feature macro: MEM_ARB_RR_EN (round-robin on ties via a last-grant
// flop; when undefined, data always wins and no flop exists).
// Ports:
//   i_clk         : clock (only present with MEM_ARB_RR_EN)
//   i_rst         : synchronous active-high reset
//   i_idle        : arbiter FSM is in IDLE and may grant
//   i_inst_valid  : fetch client requesting
//   i_data_valid  : load/store client requesting
//   o_inst_ready  : fetch request granted this cycle
//   o_data_ready  : load/store request granted this cycle
//   o_grant       : some request is granted this cycle
//   o_owner_data  : selected owner (1 = DATA, 0 = INST)
module mem_arb_grant
  import mem_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic i_clk,
`endif
  input  logic i_rst,
  input  logic i_idle,
  input  logic i_inst_valid,
  input  logic i_data_valid,
  output logic o_inst_ready,
  output logic o_data_ready,
  output logic o_grant,
  output logic o_owner_data
);

  arb_owner_e w_owner;

`ifdef MEM_ARB_RR_EN
  arb_owner_e r_last_grant;

  // Track the winner of the most recent grant so a tie goes to the other client.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= MEM_OWNER_INST;
    end else if (o_grant) begin
      r_last_grant <= w_owner;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  // Alternate only on a tie; a lone requester always wins.
  always_comb begin
    w_owner = MEM_OWNER_INST;
    if (i_data_valid && i_inst_valid) begin
      if (r_last_grant == MEM_OWNER_INST) begin
        w_owner = MEM_OWNER_DATA;
      end else begin
        w_owner = MEM_OWNER_INST;
      end
    end else if (i_data_valid) begin
      w_owner = MEM_OWNER_DATA;
    end else begin
      w_owner = MEM_OWNER_INST;
    end
  end
`else
  // Data wins whenever it requests: the ME-stage instruction is older.
  always_comb begin
    w_owner = MEM_OWNER_INST;
    if (i_data_valid) begin
      w_owner = MEM_OWNER_DATA;
    end else begin
      w_owner = MEM_OWNER_INST;
    end
  end
`endif

  // Grant only in IDLE and never while reset is held, so the readys read 0 in reset.
  always_comb begin
    o_grant      = i_idle & ~i_rst & (i_inst_valid | i_data_valid);
    o_data_ready = o_grant & (w_owner == MEM_OWNER_DATA);
    o_inst_ready = o_grant & (w_owner == MEM_OWNER_INST);
    o_owner_data = (w_owner == MEM_OWNER_DATA);
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port arbiter between the IF fetch client and the ME
// load/store client in front of the unified memory model. One transaction at
// a time: IDLE (grant) -> REQ (present to memory) -> WAIT (await response)
// -> RESP (one-cycle response pulse to the owner).
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie-break, see mem_arb_grant).
// Ports:
//   i_clk, i_rst                       : clock, synchronous active-high reset
//   i_inst_req_valid / o_inst_req_ready: fetch request handshake, i_inst_addr
//   o_inst_resp_valid, o_inst_resp_data: fetch response pulse and held data
//   i_data_req_valid / o_data_req_ready: load/store handshake with wen/addr/wdata/wmask
//   o_data_resp_valid, o_data_resp_rdata: load/store response pulse and held load data
//   o_mem_req_* / i_mem_req_ready      : memory request channel
//   i_mem_resp_valid, i_mem_resp_data  : memory response (also acks writes)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = REG_BUS,
  parameter int DATA_W = REG_BUS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inst_req_valid,
  output logic              o_inst_req_ready,
  input  logic [ADDR_W-1:0] i_inst_addr,
  output logic              o_inst_resp_valid,
  output logic [DATA_W-1:0] o_inst_resp_data,
  input  logic              i_data_req_valid,
  output logic              o_data_req_ready,
  input  logic              i_data_req_wen,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [DATA_W-1:0] i_data_wdata,
  input  logic [DATA_W-1:0] i_data_wmask,
  output logic              o_data_resp_valid,
  output logic [DATA_W-1:0] o_data_resp_rdata,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_req_wen,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  output logic [DATA_W-1:0] o_mem_req_wdata,
  output logic [DATA_W-1:0] o_mem_req_wmask,
  input  logic              i_mem_resp_valid,
  input  logic [DATA_W-1:0] i_mem_resp_data
);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  arb_owner_e        r_owner;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_wmask;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;
  logic              w_grant;
  logic              w_owner_data;

  mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
    .i_clk        (i_clk),
`endif
    .i_rst        (i_rst),
    .i_idle       (r_state == MEM_ARB_IDLE),
    .i_inst_valid (i_inst_req_valid),
    .i_data_valid (i_data_req_valid),
    .o_inst_ready (o_inst_req_ready),
    .o_data_ready (o_data_req_ready),
    .o_grant      (w_grant),
    .o_owner_data (w_owner_data)
  );

  // State register, request latch on grant, and response data capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= MEM_ARB_IDLE;
      r_owner      <= MEM_OWNER_INST;
      r_wen        <= 1'b0;
      r_addr       <= {ADDR_W{1'b0}};
      r_wdata      <= {DATA_W{1'b0}};
      r_wmask      <= {DATA_W{1'b0}};
      r_inst_rdata <= {DATA_W{1'b0}};
      r_data_rdata <= {DATA_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_owner <= arb_owner_e'(w_owner_data);
        if (w_owner_data) begin
          r_wen  <= i_data_req_wen;
          r_addr <= i_data_addr;
          // Reads carry zero write data/mask to memory regardless of client inputs.
          r_wdata <= i_data_req_wen ? i_data_wdata : {DATA_W{1'b0}};
          r_wmask <= i_data_req_wen ? i_data_wmask : {DATA_W{1'b0}};
        end else begin
          r_wen   <= 1'b0;
          r_addr  <= i_inst_addr;
          r_wdata <= {DATA_W{1'b0}};
          r_wmask <= {DATA_W{1'b0}};
        end
      end else begin
        r_owner <= r_owner;
        r_wen   <= r_wen;
        r_addr  <= r_addr;
        r_wdata <= r_wdata;
        r_wmask <= r_wmask;
      end
      // Store acknowledgements leave the load data register untouched.
      if ((r_state == MEM_ARB_WAIT) && i_mem_resp_valid) begin
        if (r_owner == MEM_OWNER_INST) begin
          r_inst_rdata <= i_mem_resp_data;
        end else if (!r_wen) begin
          r_data_rdata <= i_mem_resp_data;
        end else begin
          r_data_rdata <= r_data_rdata;
        end
      end else begin
        r_inst_rdata <= r_inst_rdata;
        r_data_rdata <= r_data_rdata;
      end
    end
  end

  // Next-state and state-decoded outputs; memory fields read 0 outside REQ.
  always_comb begin
    w_next_state      = r_state;
    o_mem_req_valid   = 1'b0;
    o_mem_req_wen     = 1'b0;
    o_mem_req_addr    = {ADDR_W{1'b0}};
    o_mem_req_wdata   = {DATA_W{1'b0}};
    o_mem_req_wmask   = {DATA_W{1'b0}};
    o_inst_resp_valid = 1'b0;
    o_data_resp_valid = 1'b0;
    case (r_state)
      MEM_ARB_IDLE: begin
        if (w_grant) begin
          w_next_state = MEM_ARB_REQ;
        end else begin
          w_next_state = MEM_ARB_IDLE;
        end
      end
      MEM_ARB_REQ: begin
        o_mem_req_valid = 1'b1;
        o_mem_req_wen   = r_wen;
        o_mem_req_addr  = r_addr;
        o_mem_req_wdata = r_wdata;
        o_mem_req_wmask = r_wmask;
        if (i_mem_req_ready) begin
          w_next_state = MEM_ARB_WAIT;
        end else begin
          w_next_state = MEM_ARB_REQ;
        end
      end
      MEM_ARB_WAIT: begin
        if (i_mem_resp_valid) begin
          w_next_state = MEM_ARB_RESP;
        end else begin
          w_next_state = MEM_ARB_WAIT;
        end
      end
      MEM_ARB_RESP: begin
        if (r_owner == MEM_OWNER_DATA) begin
          o_data_resp_valid = 1'b1;
        end else begin
          o_inst_resp_valid = 1'b1;
        end
        w_next_state = MEM_ARB_IDLE;
      end
      default: begin
        w_next_state = MEM_ARB_IDLE;
      end
    endcase
  end

  assign o_inst_resp_data  = r_inst_rdata;
  assign o_data_resp_rdata = r_data_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter with a
// reactive memory model that applies per-transaction ready/response delays.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req_valid, inst_req_ready, inst_resp_valid;
  logic [63:0] inst_addr, inst_resp_data;
  logic        data_req_valid, data_req_ready, data_req_wen, data_resp_valid;
  logic [63:0] data_addr, data_wdata, data_wmask, data_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_req_wmask, mem_resp_data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        is_data;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic [63:0] mem_rdata;
    logic [63:0] exp_wdata;
    logic [63:0] exp_wmask;
    logic [63:0] exp_rdata;
    int          req_dly;
    int          resp_dly;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_inst_req_valid  (inst_req_valid),
    .o_inst_req_ready  (inst_req_ready),
    .i_inst_addr       (inst_addr),
    .o_inst_resp_valid (inst_resp_valid),
    .o_inst_resp_data  (inst_resp_data),
    .i_data_req_valid  (data_req_valid),
    .o_data_req_ready  (data_req_ready),
    .i_data_req_wen    (data_req_wen),
    .i_data_addr       (data_addr),
    .i_data_wdata      (data_wdata),
    .i_data_wmask      (data_wmask),
    .o_data_resp_valid (data_resp_valid),
    .o_data_resp_rdata (data_resp_rdata),
    .o_mem_req_valid   (mem_req_valid),
    .i_mem_req_ready   (mem_req_ready),
    .o_mem_req_wen     (mem_req_wen),
    .o_mem_req_addr    (mem_req_addr),
    .o_mem_req_wdata   (mem_req_wdata),
    .o_mem_req_wmask   (mem_req_wmask),
    .i_mem_resp_valid  (mem_resp_valid),
    .i_mem_resp_data   (mem_resp_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic is_data, input logic wen, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] wmask,
                              input logic [63:0] mem_rdata, input logic [63:0] exp_wdata,
                              input logic [63:0] exp_wmask, input logic [63:0] exp_rdata,
                              input int req_dly, input int resp_dly, input int exp_lat);
    vec_t v;
    v.is_data = is_data; v.wen = wen; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
    v.mem_rdata = mem_rdata; v.exp_wdata = exp_wdata; v.exp_wmask = exp_wmask;
    v.exp_rdata = exp_rdata; v.req_dly = req_dly; v.resp_dly = resp_dly; v.exp_lat = exp_lat;
    return v;
  endfunction

  // Drive a client's request fields and raise its valid (no settle/check).
  task automatic drive(input vec_t v);
    if (v.is_data) begin
      data_req_valid = 1'b1; data_req_wen = v.wen; data_addr = v.addr;
      data_wdata = v.wdata; data_wmask = v.wmask;
    end else begin
      inst_req_valid = 1'b1; inst_addr = v.addr;
    end
  endtask

  // Called in the grant cycle: plays memory until the response pulse (bounded).
  task automatic serve(input vec_t v);
    int  lat;
    int  rq;
    int  ws;
    bit  acc;
    lat = -1; rq = 0; ws = 0; acc = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (v.is_data) data_req_valid = 1'b0; else inst_req_valid = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 64'h0BAD_0BAD_0BAD_0BAD;
      #1;
      if (c == 1) chk("req_at_t1", {63'd0, mem_req_valid}, 64'd1);
      if (inst_resp_valid || data_resp_valid) begin
        lat = c;
        break;
      end
      chk("ready_busy", {63'd0, inst_req_ready | data_req_ready}, 64'd0);
      if (mem_req_valid) begin
        chk("req_wen",   {63'd0, mem_req_wen}, {63'd0, v.wen});
        chk("req_addr",  mem_req_addr,  v.addr);
        chk("req_wdata", mem_req_wdata, v.exp_wdata);
        chk("req_wmask", mem_req_wmask, v.exp_wmask);
        if (rq == v.req_dly) begin
          mem_req_ready = 1'b1;
          acc = 1'b1;
        end
        rq++;
      end else if (acc) begin
        if (ws == v.resp_dly) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = v.mem_rdata;
        end
        ws++;
      end
    end
    chk("latency", 64'(lat), 64'(v.exp_lat));
    if (lat < 0) return;
    chk("resp_owner", {62'd0, data_resp_valid, inst_resp_valid}, v.is_data ? 64'd2 : 64'd1);
    chk("resp_data", v.is_data ? data_resp_rdata : inst_resp_data, v.exp_rdata);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    #1;
    chk("resp_pulse", {62'd0, data_resp_valid, inst_resp_valid}, 64'd0);
    chk("resp_hold", v.is_data ? data_resp_rdata : inst_resp_data, v.exp_rdata);
  endtask

  initial begin : main
    vec_t dv;
    vec_t iv;
    // is_data wen addr wdata wmask mem_rdata exp_wdata exp_wmask exp_rdata rq rs lat
    vecs[0] = mk(1'b1, 1'b0, 64'h8000_0010, 64'h0, 64'h0, 64'h1122_3344_5566_7788,
                 64'h0, 64'h0, 64'h1122_3344_5566_7788, 0, 0, 3);
    vecs[1] = mk(1'b1, 1'b1, 64'h8000_0020, 64'hAB00, 64'hFF00, 64'hDEAD_BEEF_DEAD_BEEF,
                 64'hAB00, 64'hFF00, 64'h1122_3344_5566_7788, 0, 0, 3);
    vecs[2] = mk(1'b0, 1'b0, 64'h8000_0000, 64'h0, 64'h0, 64'h0000_0013_0000_0093,
                 64'h0, 64'h0, 64'h0000_0013_0000_0093, 0, 0, 3);
    vecs[3] = mk(1'b1, 1'b0, 64'h8000_0040, 64'h5555, 64'hFFFF, 64'hCAFE_F00D_1234_5678,
                 64'h0, 64'h0, 64'hCAFE_F00D_1234_5678, 3, 2, 8);
    vecs[4] = mk(1'b0, 1'b0, 64'h8000_0008, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 4);

    rst = 1'b1;
    inst_req_valid = 1'b0; inst_addr = 64'd0;
    data_req_valid = 1'b0; data_req_wen = 1'b0; data_addr = 64'd0;
    data_wdata = 64'd0; data_wmask = 64'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 64'd0;

    // Reset state: everything 0, readys held low even with a request pending.
    repeat (3) @(posedge clk);
    #1;
    inst_req_valid = 1'b1;
    #1;
    chk("rst_ready", {62'd0, inst_req_ready, data_req_ready}, 64'd0);
    chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_resp_valid", {62'd0, inst_resp_valid, data_resp_valid}, 64'd0);
    chk("rst_inst_data", inst_resp_data, 64'd0);
    chk("rst_data_data", data_resp_rdata, 64'd0);
    chk("rst_mem_fields", mem_req_addr | mem_req_wdata | mem_req_wmask | {63'd0, mem_req_wen}, 64'd0);
    inst_req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven single transactions.
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i]);
      #1;
      chk("grant_ready", {62'd0, data_req_ready, inst_req_ready},
          vecs[i].is_data ? 64'd2 : 64'd1);
      serve(vecs[i]);
    end

    // Contention after an inst grant: data wins in both arbitration modes.
    dv = mk(1'b1, 1'b0, 64'h8000_0100, 64'h0, 64'h0, 64'hA5A5_0000_0000_0001,
            64'h0, 64'h0, 64'hA5A5_0000_0000_0001, 0, 0, 3);
    iv = mk(1'b0, 1'b0, 64'h8000_0200, 64'h0, 64'h0, 64'h5A5A_0000_0000_0002,
            64'h0, 64'h0, 64'h5A5A_0000_0000_0002, 0, 0, 3);
    drive(dv); drive(iv);
    #1;
    chk("cont1_first", {62'd0, data_req_ready, inst_req_ready}, 64'd2);
    serve(dv);
    chk("cont1_second", {62'd0, data_req_ready, inst_req_ready}, 64'd1);
    serve(iv);

    // Data-only grant, then a tie: round-robin gives it to inst, fixed to data.
    dv.mem_rdata = 64'h0000_0000_0000_0077; dv.exp_rdata = 64'h0000_0000_0000_0077;
    drive(dv);
    #1;
    chk("solo_data", {62'd0, data_req_ready, inst_req_ready}, 64'd2);
    serve(dv);
    dv.mem_rdata = 64'h0000_0000_0000_0088; dv.exp_rdata = 64'h0000_0000_0000_0088;
    iv.mem_rdata = 64'h0000_0000_0000_0099; iv.exp_rdata = 64'h0000_0000_0000_0099;
    drive(dv); drive(iv);
    #1;
`ifdef MEM_ARB_RR_EN
    chk("cont2_first", {62'd0, data_req_ready, inst_req_ready}, 64'd1);
    serve(iv);
    chk("cont2_second", {62'd0, data_req_ready, inst_req_ready}, 64'd2);
    serve(dv);
`else
    chk("cont2_first", {62'd0, data_req_ready, inst_req_ready}, 64'd2);
    serve(dv);
    chk("cont2_second", {62'd0, data_req_ready, inst_req_ready}, 64'd1);
    serve(iv);
`endif

    // Reset while WAITing: outputs 0, response registers cleared, no pulse.
    iv.addr = 64'h8000_0300;
    drive(iv);
    #1;
    chk("rw_grant", {63'd0, inst_req_ready}, 64'd1);
    @(posedge clk); #1;
    inst_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    chk("rw_req", {63'd0, mem_req_valid}, 64'd1);
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 64'hFEED_FACE_FEED_FACE;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_resp_valid = 1'b0;
    #1;
    chk("rw_outputs", {61'd0, mem_req_valid, inst_resp_valid, data_resp_valid}, 64'd0);
    chk("rw_inst_data", inst_resp_data, 64'd0);
    chk("rw_data_data", data_resp_rdata, 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rw_no_pulse", {62'd0, inst_resp_valid, data_resp_valid}, 64'd0);
    end
    iv.addr = 64'h8000_0400; iv.mem_rdata = 64'h1357_9BDF_2468_ACE0;
    iv.exp_rdata = 64'h1357_9BDF_2468_ACE0;
    drive(iv);
    #1;
    chk("rw_refetch", {63'd0, inst_req_ready}, 64'd1);
    serve(iv);

    // Idle: no requests, memory stays quiet.
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("idle_req", {63'd0, mem_req_valid}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
